pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake, optional 2-entry skid buffer, synchronous flush with bubble insertion, and a saturating stall counter. It replaces the fixed-field inter-stage registers in the 5-stage processor, and is first used at ID/EX. Control and payload are carried as separate buses: control bits are zeroed on a bubble, while payload is left to hold.

---
 rtl/pipe_stage_skid.sv | 123 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage register with a valid/ready handshake.
// A main register drives the outputs; with SKID=1 a second skid register
// absorbs one extra beat so in_ready can be a registered signal.
// All state moves on the falling clock edge, like the rest of the pipeline.
//
// Handshake: a beat moves in when in_valid & in_ready (in_fire) and moves out
// when out_valid & out_ready (out_fire), both sampled at the falling edge.
// out_valid never depends on out_ready; with SKID=1 in_ready is a flop, with
// SKID=0 it is ~out_valid | out_ready. out_ctrl is all zero while out_valid=0.
module pipe_stage_skid #(
  parameter int CTRL_W = 11,
  parameter int DATA_W = 164,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              ready_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = state;

  // SKID=1 uses the registered ready; SKID=0 can accept whenever the output
  // slot is free or being drained this cycle.
  assign in_ready = (SKID != 0) ? ready_q : (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Stall counter: cycles where a beat waits on downstream; saturates and
  // survives flush so it reflects total back-pressure since reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Occupancy FSM with its storage; flush empties the stage and zeroes the
  // control bits so the bubble carries no side effects downstream.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      ready_q   <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      ready_q   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (in_fire) begin
            // Only reachable with SKID=1: SKID=0 refuses input while held.
            state     <= FULL;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            ready_q   <= 1'b0;
          end else if (out_fire) begin
            state     <= EMPTY;
            main_ctrl <= '0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          main_ctrl <= '0;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances share one stimulus stream
// (SKID=1 default, SKID=0, SKID=1 with a 4-bit stall counter). Each has a
// FIFO reference model holding up to its capacity of beats.
module tb_pipe_stage_skid;

  localparam int CW = 11;
  localparam int DW = 164;
  localparam int BW = CW + DW;

  typedef logic [BW-1:0] beat_t;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          ir  [3];
  logic          ov  [3];
  logic [CW-1:0] oc  [3];
  logic [DW-1:0] od  [3];
  logic [1:0]    occ [3];
  logic [15:0]   sc0;
  logic [15:0]   sc1;
  logic [3:0]    sc2;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]), .stall_cnt(sc0));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]), .stall_cnt(sc1));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .occupancy(occ[2]), .stall_cnt(sc2));

  // scoreboard: one expected queue per instance
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  beat_t exp_q2[$];
  int    mcnt [3];
  int    cap  [3] = '{2, 1, 2};
  int    cmax [3] = '{65535, 65535, 15};
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic int qsize(int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic beat_t qfront(int i);
    case (i)
      0: return exp_q0[0];
      1: return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic qpush(int i, beat_t b);
    case (i)
      0: exp_q0.push_back(b);
      1: exp_q1.push_back(b);
      default: exp_q2.push_back(b);
    endcase
  endtask

  task automatic qpop(int i);
    case (i)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic qclear(int i);
    case (i)
      0: exp_q0.delete();
      1: exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  // Acceptance rule: the skid stage takes a beat while it has a free entry;
  // the single-entry stage takes one when empty or when its beat leaves now.
  function automatic logic m_ready(int i);
    if (cap[i] == 2) return (qsize(i) < 2);
    return (qsize(i) == 0) || out_ready;
  endfunction

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_cnt(int i);
    case (i)
      0: return sc0;
      1: return sc1;
      default: return {12'd0, sc2};
    endcase
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      logic  v;
      beat_t b;
      v = (qsize(i) > 0);
      b = v ? qfront(i) : '0;
      check($sformatf("in_ready[%0d]", i), 256'(ir[i]), 256'(m_ready(i)));
      check($sformatf("out_valid[%0d]", i), 256'(ov[i]), 256'(v));
      check($sformatf("out_ctrl[%0d]", i), 256'(oc[i]), 256'(b[BW-1:DW]));
      if (v) check($sformatf("out_data[%0d]", i), 256'(od[i]), 256'(b[DW-1:0]));
      if (!rst) check($sformatf("rst_data[%0d]", i), 256'(od[i]), 256'(0));
      check($sformatf("occupancy[%0d]", i), 256'(occ[i]), 256'(qsize(i)));
      check($sformatf("stall_cnt[%0d]", i), 256'(dut_cnt(i)), 256'(mcnt[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      qclear(i);
      mcnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic v;
        logic r;
        v = (qsize(i) > 0);
        r = m_ready(i);
        if (v && !out_ready && mcnt[i] < cmax[i]) mcnt[i]++;
        if (flush) begin
          qclear(i);
        end else begin
          if (v && out_ready) qpop(i);
          if (in_valid && r) qpush(i, {in_ctrl, in_data});
        end
      end
    end
  endtask

  // One cycle: inputs already driven just after the rising edge.
  task automatic tick();
    if (!rst) model_reset();
    #2;
    compare_all();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // driver
  task automatic drive(logic v, logic [CW-1:0] c, logic [DW-1:0] d, logic ordy, logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 11'h7ff, rand_data(), 1'b0, 1'b0);
    model_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // reset holds everything empty even with a valid beat presented
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 11'h7ff, rand_data(), 1'b0, 1'b0);
      tick();
    end

    // release: first beat taken at the next falling edge
    rst = 1'b1;
    drive(1'b1, 11'h155, 164'h55, 1'b1, 1'b0);
    tick();
    drive(1'b0, 11'h000, 164'h0, 1'b1, 1'b0);
    tick();

    // streaming 1..8 back to back
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 11'(k), DW'(k), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 11'h0, '0, 1'b1, 1'b0);
    tick();
    tick();

    // backpressure: A, B (and a refused C) then drain
    drive(1'b1, 11'h0aa, 164'hA, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11'h0bb, 164'hB, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11'h0cc, 164'hC, 1'b0, 1'b0);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 11'h0, '0, 1'b1, 1'b0);
      tick();
    end

    // flush while full with a beat presented, then a normal beat
    drive(1'b1, 11'h101, 164'h101, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11'h102, 164'h102, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11'h7ff, 164'hdead, 1'b0, 1'b1);
    tick();
    drive(1'b1, 11'h104, 164'h104, 1'b1, 1'b0);
    tick();
    drive(1'b0, 11'h0, '0, 1'b1, 1'b0);
    tick();
    tick();

    // single-entry stage: hold one beat, then release in the same cycle
    drive(1'b1, 11'h0e1, 164'hE1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11'h0e2, 164'hE2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 11'h0e2, 164'hE2, 1'b1, 1'b0);
    tick();
    drive(1'b0, 11'h0, '0, 1'b1, 1'b0);
    tick();
    tick();
    tick();

    // saturation: long stall
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 11'($urandom), rand_data(), 1'b0, 1'b0);
      tick();
    end
    check("sat_hold", 256'(sc2), 256'(15));
    drive(1'b0, 11'h0, '0, 1'b0, 1'b0);
    tick();
    check("sat_stay", 256'(sc2), 256'(15));

    // randomized traffic with occasional flush and asynchronous reset
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), 11'($urandom), rand_data(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 11'h0, '0, 1'b1, 1'b0);
    tick();
    tick();
    tick();

    // report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
